// File: rtl/exec_cycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK sequencer that drives the PC control strobes.
// Optional macro FETCH_TIMEOUT_EN adds a sticky fault when an instruction fetch is never acknowledged.
module exec_cycle_controller #(
    parameter int unsigned PC_STEP       = 4,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_address,
    output logic        pc_write_en,
    output logic        pc_load,
    output logic [31:0] pc_new,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_op,
    input  logic        dmem_done,
    input  logic        halt,
    output logic [2:0]  stage,
    output logic        retired,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ack) begin
                r_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);
    logic [7:0] r_fetch_cnt;

    // Zero everywhere outside an unacknowledged FETCH, so each FETCH entry starts from 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_cnt <= '0;
        end else if (r_state == S_FETCH && !imem_ack) begin
            r_fetch_cnt <= r_fetch_cnt + 8'd1;
        end else begin
            r_fetch_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (FETCH_TIMEOUT == 0);
`endif

    // NOTE: every output and the next state get a default first, so no path through the case infers a latch.
    always_comb begin
        w_next      = r_state;
        pc_write_en = 1'b0;
        pc_load     = 1'b0;
        pc_new      = '0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        retired     = 1'b0;
        fault       = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_address;
                if (imem_ack) begin
                    w_next = S_DECODE;
`ifdef FETCH_TIMEOUT_EN
                end else if (r_fetch_cnt == TIMEOUT_LAST) begin
                    w_next = S_FAULT;
`endif
                end
            end
            S_DECODE: w_next = S_EXECUTE;
            S_EXECUTE: begin
                pc_write_en = 1'b1;
                pc_load     = 1'b1;
                pc_new      = branch_taken ? branch_target : pc_address + 32'(PC_STEP);
                w_next      = mem_op ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dmem_done) begin
                    w_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                retired = 1'b1;
                w_next  = halt ? S_HALT : S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            S_FAULT: begin
`ifdef FETCH_TIMEOUT_EN
                fault = 1'b1;
`endif
                w_next = S_FAULT;
            end
        endcase
    end

    assign stage = r_state;
    assign instr = r_instr;

endmodule

// File: tb/tb_exec_cycle_controller.sv
// Self-checking bench for exec_cycle_controller: directed cases plus randomized instructions
// checked cycle by cycle against a per-instruction stage plan and a PC model.
module tb_exec_cycle_controller;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXECUTE = 3;
    localparam int ST_MEMORY = 4, ST_WB = 5, ST_HALT = 6, ST_FAULT = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_address = '0;
    logic        pc_write_en, pc_load;
    logic [31:0] pc_new;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_op = 1'b0;
    logic        dmem_done = 1'b0;
    logic        halt = 1'b0;
    logic [2:0]  stage;
    logic        retired, fault;

    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_model = '0;
    logic [31:0] exp_instr = '0;

    always #5 clk = ~clk;

    exec_cycle_controller #(.PC_STEP(4), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .pc_address(pc_address),
        .pc_write_en(pc_write_en), .pc_load(pc_load), .pc_new(pc_new),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_op(mem_op), .dmem_done(dmem_done),
        .halt(halt), .stage(stage), .retired(retired), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int st, input logic [31:0] exp_pcnew);
        check("stage", 32'(stage), 32'(st));
        check("imem_req", 32'(imem_req), 32'(st == ST_FETCH));
        check("imem_addr", imem_addr, (st == ST_FETCH) ? pc_model : 32'h0);
        check("pc_write_en", 32'(pc_write_en), 32'(st == ST_EXECUTE));
        check("pc_load", 32'(pc_load), 32'(st == ST_EXECUTE));
        check("pc_new", pc_new, (st == ST_EXECUTE) ? exp_pcnew : 32'h0);
        check("retired", 32'(retired), 32'(st == ST_WB));
        check("fault", 32'(fault), 32'(st == ST_FAULT));
        check("instr", instr, exp_instr);
    endtask

    // Entered at posedge+1; leaves at posedge+1 of the first FETCH cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0; dmem_done = 1'b0; halt = 1'b0;
        branch_taken = 1'b0; mem_op = 1'b0;
        exp_instr = '0;
        #1;
        check_outputs(ST_IDLE, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check_outputs(ST_IDLE, 32'h0);
        @(posedge clk); #1;
    endtask

    // One instruction: builds the expected stage list from the instruction's parameters,
    // then drives and checks each cycle. Unsampled inputs carry random noise.
    task automatic run_instr(input logic [31:0] rdata, input int ack_wait, input logic br,
                             input logic [31:0] tgt, input logic mop, input int dwait,
                             input logic hlt);
        int          plan[$];
        int          fcnt = 0;
        int          mcnt = 0;
        logic [31:0] exp_pcnew;
        for (int i = 0; i <= ack_wait; i++) plan.push_back(ST_FETCH);
        plan.push_back(ST_DECODE);
        plan.push_back(ST_EXECUTE);
        if (mop) for (int i = 0; i <= dwait; i++) plan.push_back(ST_MEMORY);
        plan.push_back(ST_WB);
        exp_pcnew = br ? tgt : pc_model + 32'd4;
        foreach (plan[k]) begin
            int st = plan[k];
            pc_address    = pc_model;
            imem_ack      = (st == ST_FETCH) ? (fcnt == ack_wait) : 1'($urandom_range(0, 1));
            imem_rdata    = (st == ST_FETCH) ? rdata : $urandom;
            dmem_done     = (st == ST_MEMORY) ? (mcnt == dwait) : 1'($urandom_range(0, 1));
            branch_taken  = (st == ST_EXECUTE) ? br : 1'($urandom_range(0, 1));
            branch_target = (st == ST_EXECUTE) ? tgt : $urandom;
            mem_op        = (st == ST_EXECUTE) ? mop : 1'($urandom_range(0, 1));
            halt          = (st == ST_WB) ? hlt : 1'($urandom_range(0, 1));
            #1;
            check_outputs(st, exp_pcnew);
            @(posedge clk); #1;
            if (st == ST_FETCH) begin
                if (fcnt == ack_wait) exp_instr = rdata;
                fcnt++;
            end
            if (st == ST_MEMORY) mcnt++;
            if (st == ST_EXECUTE) pc_model = exp_pcnew;
        end
    endtask

    task automatic hold_state(input int st, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_ack     = 1'($urandom_range(0, 1));
            dmem_done    = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            mem_op       = 1'($urandom_range(0, 1));
            halt         = 1'($urandom_range(0, 1));
            imem_rdata   = $urandom;
            #1;
            check_outputs(st, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic sequential instruction from address 0
        pc_model = 32'h0;
        run_instr(32'h00A00093, 0, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // Taken branch; the following fetch must use the branch target
        pc_model = 32'h10;
        run_instr($urandom, 0, 1'b1, 32'h200, 1'b0, 0, 1'b0);

        // Memory op with dmem_done three cycles after MEMORY entry
        run_instr($urandom, 0, 1'b0, 32'h0, 1'b1, 3, 1'b0);

        // Sequential PC wraps to zero
        pc_model = 32'hFFFF_FFFC;
        run_instr($urandom, 1, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // Ack arrives in the 16th FETCH cycle
        run_instr($urandom, 15, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // Reset in the third cycle of a stalled fetch
        pc_model = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            pc_address = pc_model;
            imem_ack   = 1'b0;
            #1;
            check_outputs(ST_FETCH, 32'h0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        do_reset();
        run_instr($urandom, 0, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // Randomized instruction mix
        for (int n = 0; n < 24; n++) begin
            run_instr($urandom, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                      $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), 1'b0);
        end

        // Halt after the next instruction; HALT is absorbing
        run_instr($urandom, 0, 1'b0, 32'h0, 1'b1, 1, 1'b1);
        hold_state(ST_HALT, 6);

`ifdef FETCH_TIMEOUT_EN
        // Fetch never acknowledged: 16 FETCH cycles, then sticky FAULT
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pc_address = pc_model;
            imem_ack   = 1'b0;
            #1;
            check_outputs(ST_FETCH, 32'h0);
            @(posedge clk); #1;
        end
        hold_state(ST_FAULT, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_cycle_controller.md
Name: exec_cycle_controller

Overview:
- Multi-cycle instruction sequencer that owns the program counter's control inputs (write_en, load, new_pc).
- Fetches from instruction memory through a req/ack handshake and holds the fetched word in an instruction register.
- Steps FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK, then redirects the PC to the sequential or branch address once per instruction.
- Sits between the program counter, instruction memory and the decode/execute datapath.

Parameters:
- PC_STEP, 4, byte increment for a sequential next PC.
- FETCH_TIMEOUT, 16, cycles FETCH may wait for imem_ack before faulting. Used only with FETCH_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_address  in  32  current PC from the program counter.
- pc_write_en  out  1  PC write enable.
- pc_load  out  1  PC load strobe.
- pc_new  out  32  next PC value presented to the program counter.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  instruction register.
- branch_taken  in  1  branch resolved taken; sampled in EXECUTE only.
- branch_target  in  32  branch destination; sampled in EXECUTE only.
- mem_op  in  1  current instruction needs the MEMORY stage; sampled in EXECUTE only.
- dmem_done  in  1  data memory access complete; sampled in MEMORY only.
- halt  in  1  stop after this instruction; sampled in WRITEBACK only.
- stage  out  3  current state encoding.
- retired  out  1  one-cycle pulse when an instruction completes.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, instr=0, timeout counter=0.
  - Every output is 0, including stage and fault.
  - Deassertion is synchronous to clk.
  - Reset mid-operation aborts the instruction; the in-flight imem_req drops immediately.
- IDLE: one cycle, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_address.
  - On imem_ack=1: instr<=imem_rdata and go to DECODE on the same edge. A zero-wait fetch therefore spends one cycle in FETCH.
  - Without ack: remain in FETCH with req held.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: one cycle.
  - pc_write_en=1, pc_load=1.
  - pc_new=branch_target if branch_taken, else pc_address+PC_STEP, truncated to 32 bits (0xFFFFFFFC+4 wraps to 0).
  - Next state: MEMORY if mem_op=1, else WRITEBACK.
- MEMORY: stay until dmem_done=1, then WRITEBACK.
- WRITEBACK: one cycle, retired=1.
  - halt=1 leads to HALT; otherwise FETCH.
- HALT: absorbing until reset; all strobes 0.
- Output timing: all outputs are Moore decodes of the state register. Outside their active states:
  - pc_write_en, pc_load, imem_req and retired are 0.
  - pc_new and imem_addr are 0.
  - instr holds its value.
- Stray inputs: imem_ack outside FETCH and dmem_done outside MEMORY are ignored.
- Latency: a non-memory instruction with zero-wait fetch takes 4 cycles (FETCH..WRITEBACK). With a memory op it takes 5 + dmem wait cycles.
- The PC updates exactly once per instruction, at the end of EXECUTE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on FETCH entry and increments each FETCH cycle without ack.
  - When it reaches FETCH_TIMEOUT, go to FAULT: fault=1 (sticky), imem_req=0, no PC write, exit only by reset.
  - An ack in the final cycle wins over the timeout.
- Undefined: FETCH waits indefinitely, fault is tied 0, and the FAULT state is unreachable.

Test Plan:
- Reset release, pc_address=0x0, imem_ack tied 1, imem_rdata=0x00A00093, branch_taken=0, mem_op=0 -> stage sequence 0,1,2,3,5,1 (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH). instr=0x00A00093. During EXECUTE: pc_write_en=pc_load=1, pc_new=0x4. retired pulses once.
- pc_address=0x10, branch_taken=1, branch_target=0x200 in EXECUTE -> pc_new=0x200. Next FETCH imem_addr=0x200 (PC model updated).
- mem_op=1, dmem_done asserted 3 cycles after MEMORY entry -> 4 MEMORY cycles, then WRITEBACK. Instruction total 8 cycles.
- pc_address=0xFFFFFFFC, no branch -> pc_new=0x00000000.
- imem_ack delayed 5 cycles, reset_n pulsed low in the 3rd FETCH cycle -> immediately stage=0, imem_req=0, instr=0. After release, the sequence restarts from IDLE.
- FETCH_TIMEOUT_EN with FETCH_TIMEOUT=16, imem_ack never asserted -> after 16 FETCH cycles stage=7, fault=1, imem_req=0. Values hold until reset. halt=1 in WRITEBACK -> stage=6 and stays there.
